alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single 16-bit ALU between two instruction requesters.
//  - Round-robin arbitration between the two requesters.
//  - Issues one instruction at a time and waits for ALU completion.
//  - Returns a completion or error response to the requester that was granted.
//  - Sits between the instruction sources and the ALU instruction input.
//  - Guarantees exactly one instruction in flight in the register-file ALU.
// PARAMETERS
//  TIMEOUT     16       max cycles in WAIT before abort; legal range 1..255
//  LEGAL_MASK  16'h807B bit k=1 -> opcode k legal (ADD0 SUB1 AND3 OR4 XOR5 NOT6 LDI15)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  req0_valid   in   1   requester 0 has an instruction
//  req0_instr   in   16  {op[15:12], ra/rd[11:8], rb/imm[7:0]} instruction word
//  req0_ready   out  1   requester 0 accepted when valid&ready at posedge
//  req1_valid   in   1   requester 1 has an instruction
//  req1_instr   in   16  same format as req0_instr
//  req1_ready   out  1   requester 1 accepted when valid&ready at posedge
//  alu_instr    out  16  instruction presented to the ALU
//  alu_start    out  1   one-cycle pulse: ALU begins executing alu_instr
//  alu_done     in   1   ALU completion strobe
//  alu_abort    out  1   one-cycle pulse on timeout
//  rsp_valid    out  2   one-hot, one-cycle completion pulse per requester
//  rsp_err      out  1   qualifies rsp_valid: 1 = illegal opcode or timeout
//  rsp_dst      out  4   destination reg: instr[11:8] if op=1111, else instr[3:0]
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_last=1 (req0 wins first), wait_cnt=0.
//   All outputs are 0, including alu_instr and rsp_dst.
//  Reset mid-operation: the in-flight instruction is dropped.
//   No rsp and no abort pulse is emitted.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE:
//   - Grant goes to the only valid requester.
//   - If both requesters are valid, grant goes to ~rr_last.
//   - Only the granted requester sees ready=1, and ready is combinational in IDLE only.
//   - On accept: latch instr and grant id; rr_last <= grant id.
//   - Accepted opcode illegal per LEGAL_MASK -> RESP with err=1, alu_start never asserted.
//   - Otherwise -> ISSUE.
//  ISSUE: alu_start=1 for exactly this cycle; alu_instr=latched instr; -> WAIT with wait_cnt=0.
//  WAIT:
//   - alu_instr stays held.
//   - alu_done=1 -> RESP with err=0.
//   - Else wait_cnt++; when wait_cnt reaches TIMEOUT-1 -> alu_abort pulse, -> RESP with err=1.
//   - alu_done on the timeout cycle: done wins, no abort.
//  RESP: rsp_valid[grant]=1, rsp_err and rsp_dst valid this cycle only; -> IDLE.
//  alu_done outside WAIT is ignored (no state change, no response).
//  alu_instr returns to 0 in IDLE and RESP.
//  Latency, accept at cycle N with done at first WAIT cycle:
//   - alu_start at N+1.
//   - rsp at N+3.
//   - Next accept possible at N+4.
//  Illegal opcode: accept at N, rsp at N+1.
//  Requester valid may drop without accept; that is not an error.
//  A requester not granted keeps its instr stable (its own duty).
// TESTING
//  1 After rst, req0 ADD {0,1,2,3} with done one cycle after start:
//    alu_start at N+1, rsp_valid=2'b01, err=0, rsp_dst=3 at N+3.
//  2 Both requesters held valid for 4 transactions:
//    grants go 0,1,0,1; a loser's ready stays 0 until IDLE.
//  3 req1 instr 16'h2123 (op 0010 illegal):
//    rsp_valid=2'b10, err=1 at N+1; alu_start never pulses.
//  4 LDI 16'hF0AA with done withheld, TIMEOUT=16:
//    alu_abort and RESP err=1, rsp_dst=0 after 16 WAIT cycles.
//  5 alu_done on the same cycle as the timeout:
//    err=0, no alu_abort; stray alu_done in IDLE is ignored.
//  6 rst asserted during WAIT:
//    next cycle busy=0, all outputs 0, no rsp; new request serviced normally, req0 first.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of two requesters onto a single ALU.
// Ports: req0/req1 valid/instr/ready handshakes, alu_instr/alu_start/
//  alu_done/alu_abort ALU side, rsp_valid/rsp_err/rsp_dst response, busy.
module alu_issue_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [15:0] LEGAL_MASK = 16'h807B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [15:0] req0_instr,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_instr,
   output logic        req1_ready,
   output logic [15:0] alu_instr,
   output logic        alu_start,
   input  logic        alu_done,
   output logic        alu_abort,
   output logic [1:0]  rsp_valid,
   output logic        rsp_err,
   output logic [3:0]  rsp_dst,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic        gnt_q, gnt_d;
   logic        rr_q, rr_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        idle;
   logic        any_req;
   logic        gnt_id;
   logic [15:0] sel_instr;
   logic        sel_legal;
   logic        tmo;

   assign idle    = (state_q == IDLE);
   assign any_req = req0_valid | req1_valid;
   // Contention goes to whoever did not win last; otherwise the lone requester.
   assign gnt_id    = (req0_valid & req1_valid) ? ~rr_q : req1_valid;
   assign sel_instr = gnt_id ? req1_instr : req0_instr;
   assign sel_legal = LEGAL_MASK[sel_instr[15:12]];
   // Done in the same cycle as the last wait slot takes priority.
   assign tmo = (state_q == WAIT) & ~alu_done & (cnt_q == CNT_MAX);

   assign req0_ready = idle & req0_valid & ~gnt_id;
   assign req1_ready = idle & req1_valid & gnt_id;
   assign alu_start  = (state_q == ISSUE);
   assign alu_abort  = tmo;
   assign alu_instr  = (state_q == ISSUE || state_q == WAIT) ? instr_q : 16'h0;
   assign busy       = ~idle;

   always_comb begin
      rsp_valid = 2'b00;
      rsp_err   = 1'b0;
      rsp_dst   = 4'h0;
      if (state_q == RESP) begin
         rsp_valid = gnt_q ? 2'b10 : 2'b01;
         rsp_err   = err_q;
         rsp_dst   = (instr_q[15:12] == 4'hF) ? instr_q[11:8] : instr_q[3:0];
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               instr_d = sel_instr;
               gnt_d   = gnt_id;
               rr_d    = gnt_id;
               err_d   = ~sel_legal;
               state_d = sel_legal ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            cnt_d   = 8'h0;
            state_d = WAIT;
         end
         WAIT: begin
            if (alu_done) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= 16'h0;
         gnt_q   <= 1'b0;
         rr_q    <= 1'b1;
         err_q   <= 1'b0;
         cnt_q   <= 8'h0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench for alu_issue_arbiter.
// Stimulus and ALU responder drive; a negedge monitor checks against a model.
module tb_alu_issue_arbiter;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_instr, req1_instr;
   logic        req0_ready, req1_ready;
   logic [15:0] alu_instr;
   logic        alu_start, alu_done, alu_abort;
   logic [1:0]  rsp_valid;
   logic        rsp_err;
   logic [3:0]  rsp_dst;
   logic        busy;

   alu_issue_arbiter #(.TIMEOUT(TMO), .LEGAL_MASK(16'h807B)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
      .alu_instr(alu_instr), .alu_start(alu_start), .alu_done(alu_done),
      .alu_abort(alu_abort), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_dst(rsp_dst), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s actual=none expected=event cyc=%0d", nm, cyc);
   endtask

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
   endfunction

   function automatic logic [3:0] dst_of(input logic [15:0] i);
      return (i[15:12] == 4'hF) ? i[11:8] : i[3:0];
   endfunction

   function automatic logic [15:0] rnd_instr();
      logic [3:0] ops [7];
      logic [3:0] op;
      ops = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
      if ($urandom_range(9) < 7) op = ops[$urandom_range(6)];
      else op = 4'($urandom);
      return {op, 12'($urandom)};
   endfunction

   typedef struct {
      int          id;
      logic [15:0] instr;
      int          acc;
      int          starts;
      int          aborts;
   } ent_t;

   ent_t sb[$];
   bit   m_rr = 1'b1;
   bit   m_busy = 1'b0;
   bit   chk0 = 1'b0;
   int   exp_d = 0;
   int   fix_d = -2;
   bit   stray_req = 1'b0;

   // Monitor: reference arbitration, latency and response rules.
   always @(negedge clk) begin : mon
      bit   e0, e1, lg, to, xerr;
      int   xlat;
      ent_t ent;
      if (chk0) begin
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_outs", {alu_instr, alu_start, alu_abort, rsp_valid, rsp_err, rsp_dst}, 32'd0);
         chk0 = 1'b0;
      end
      if (rst) begin
         sb.delete();
         m_busy = 1'b0;
         m_rr = 1'b1;
         chk0 = 1'b1;
      end else begin
         e0 = !m_busy && req0_valid && (!req1_valid || m_rr);
         e1 = !m_busy && req1_valid && (!req0_valid || !m_rr);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("ready", 32'({req1_ready, req0_ready}), 32'({e1, e0}));
         if (!m_busy) chk("idle_instr", 32'(alu_instr), 32'd0);
         if (alu_start) begin
            if (sb.size() == 0) fail("start_unexp");
            else begin
               chk("start_lat", 32'(cyc - sb[0].acc), 32'd1);
               chk("start_instr", 32'(alu_instr), 32'(sb[0].instr));
               chk("start_legal", 32'(is_legal(sb[0].instr[15:12])), 32'd1);
               sb[0].starts++;
            end
         end
         if (alu_abort) begin
            if (sb.size() == 0) fail("abort_unexp");
            else sb[0].aborts++;
         end
         if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) fail("rsp_unexp");
            else begin
               ent = sb.pop_front();
               lg = is_legal(ent.instr[15:12]);
               to = lg && (exp_d < 0 || exp_d > TMO - 1);
               xerr = !lg || to;
               xlat = !lg ? 1 : 3 + (to ? TMO - 1 : exp_d);
               chk("rsp_valid", 32'(rsp_valid), (ent.id != 0) ? 32'd2 : 32'd1);
               chk("rsp_err", 32'(rsp_err), 32'(xerr));
               chk("rsp_dst", 32'(rsp_dst), 32'(dst_of(ent.instr)));
               chk("rsp_lat", 32'(cyc - ent.acc), 32'(xlat));
               chk("starts", 32'(ent.starts), 32'(lg));
               chk("aborts", 32'(ent.aborts), 32'(to));
            end
            m_busy = 1'b0;
         end else if (sb.size() > 0 && cyc > sb[0].acc + 40) begin
            fail("rsp_timeout");
            void'(sb.pop_front());
            m_busy = 1'b0;
         end
         if (e0 || e1) begin
            sb.push_back('{id: e1 ? 1 : 0, instr: e1 ? req1_instr : req0_instr,
                           acc: cyc, starts: 0, aborts: 0});
            m_busy = 1'b1;
            m_rr = e1;
         end
      end
   end

   // ALU responder: done after d WAIT cycles, or never when d < 0.
   initial begin : alu_rsp
      int d;
      alu_done = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_req) begin
            stray_req = 1'b0;
            @(posedge clk); #1 alu_done = 1'b1;
            @(posedge clk); #1 alu_done = 1'b0;
         end else if (alu_start && !rst) begin
            if (fix_d != -2) d = fix_d;
            else if ($urandom_range(3) == 0) d = -1;
            else d = int'($urandom_range(TMO - 1));
            exp_d = d;
            if (d >= 0) begin
               @(posedge clk); #1;
               repeat (d) begin @(posedge clk); #1; end
               alu_done = 1'b1;
               @(posedge clk); #1 alu_done = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) fail("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic send(input int id, input logic [15:0] ins, input int d);
      bit ok;
      fix_d = d;
      ok = 1'b0;
      if (id == 0) begin req0_valid = 1'b1; req0_instr = ins; end
      else begin req1_valid = 1'b1; req1_instr = ins; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("accept_timeout");
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
   endtask

   task automatic both(input int n, input int first);
      int  got;
      bit  a0, a1;
      got = 0;
      fix_d = 0;
      req0_valid = 1'b1; req0_instr = {4'd0, 12'($urandom)};
      req1_valid = 1'b1; req1_instr = {4'd4, 12'($urandom)};
      for (int i = 0; i < 200 && got < n; i++) begin
         @(negedge clk);
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         if (a0 || a1) begin
            chk("rr_grant", 32'(a1), 32'((first + got) % 2));
            got++;
         end
         @(posedge clk); #1;
         if (a0) req0_instr = {4'd1, 12'($urandom)};
         if (a1) req1_instr = {4'd5, 12'($urandom)};
      end
      if (got < n) fail("both_timeout");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit a0, a1;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_instr = 16'h0; req1_instr = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      send(0, 16'h0123, 0);
      send(1, 16'h2123, 0);
      send(0, 16'hF0AA, -1);
      send(1, 16'h1456, TMO - 1);
      stray_req = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      both(4, 0);

      fix_d = -1;
      req0_valid = 1'b1; req0_instr = 16'h3789;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req0_ready) break;
      end
      @(posedge clk); #1 req0_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      both(2, 0);

      fix_d = -2;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         @(posedge clk); #1;
         if (a0 || !req0_valid) begin
            req0_valid = ($urandom_range(2) != 0);
            req0_instr = rnd_instr();
         end else if ($urandom_range(15) == 0) req0_valid = 1'b0;
         if (a1 || !req1_valid) begin
            req1_valid = ($urandom_range(2) != 0);
            req1_instr = rnd_instr();
         end else if ($urandom_range(15) == 0) req1_valid = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
